// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: state encoding, port ids
// and default bus widths.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin chooser; on a tie the port that did not
// win last time is picked.
module rr_pick2 (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       valid,
    output logic       pick
);

    always_comb begin
        valid = |eligible;
        case (eligible)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_grant;
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch (port 0) and data (port 1) accesses onto a
// single-port synchronous RAM with a 3-cycle IDLE/ACCESS/CAPTURE sequence.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy,
    output logic              grant
);

    arb_state_t        r_state, w_state_nxt;
    logic              r_last_grant, w_last_grant_nxt;
    logic              r_grant, w_grant_nxt;
    logic              r_we, w_we_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done0, w_done0_nxt;
    logic              r_done1, w_done1_nxt;
    logic              r_ram_read, w_ram_read_nxt;
    logic              r_ram_write, w_ram_write_nxt;
    logic [ADDR_W-1:0] r_ram_address, w_ram_address_nxt;
    logic [DATA_W-1:0] r_ram_data_in, w_ram_data_in_nxt;
    logic [DATA_W-1:0] r_rdata0, w_rdata0_nxt;
    logic [DATA_W-1:0] r_rdata1, w_rdata1_nxt;

    logic [1:0]        w_eligible;
    logic              w_valid;
    logic              w_pick;

    // Masking with done stops a requester that is just dropping req from
    // being granted again in its own completion cycle.
    assign w_eligible = {req1 & ~r_done1, req0 & ~r_done0};

    rr_pick2 u_rr_pick2 (
        .eligible   (w_eligible),
        .last_grant (r_last_grant),
        .valid      (w_valid),
        .pick       (w_pick)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_last_grant_nxt  = r_last_grant;
        w_grant_nxt       = r_grant;
        w_we_nxt          = r_we;
        w_done0_nxt       = 1'b0;
        w_done1_nxt       = 1'b0;
        w_ram_read_nxt    = 1'b0;
        w_ram_write_nxt   = 1'b0;
        w_ram_address_nxt = r_ram_address;
        w_ram_data_in_nxt = r_ram_data_in;
        w_rdata0_nxt      = r_rdata0;
        w_rdata1_nxt      = r_rdata1;

        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt       = ACCESS;
                    w_grant_nxt       = w_pick;
                    w_last_grant_nxt  = w_pick;
                    w_we_nxt          = (w_pick == PORT_DATA) ? we1 : we0;
                    w_ram_address_nxt = (w_pick == PORT_DATA) ? addr1 : addr0;
                    w_ram_read_nxt    = ~w_we_nxt;
                    w_ram_write_nxt   = w_we_nxt;
                    if (w_we_nxt) begin
                        w_ram_data_in_nxt = (w_pick == PORT_DATA) ? wdata1 : wdata0;
                    end
                end
            end
            ACCESS: begin
                w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                w_state_nxt = IDLE;
                if (r_grant == PORT_DATA) begin
                    w_done1_nxt = 1'b1;
                    if (!r_we) w_rdata1_nxt = ram_data_out;
                end else begin
                    w_done0_nxt = 1'b1;
                    if (!r_we) w_rdata0_nxt = ram_data_out;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state       <= IDLE;
            r_last_grant  <= PORT_DATA;
            r_grant       <= PORT_FETCH;
            r_we          <= 1'b0;
            r_busy        <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_ram_read    <= 1'b0;
            r_ram_write   <= 1'b0;
            r_ram_address <= '0;
            r_ram_data_in <= '0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_grant       <= w_grant_nxt;
            r_we          <= w_we_nxt;
            r_busy        <= w_busy_nxt;
            r_done0       <= w_done0_nxt;
            r_done1       <= w_done1_nxt;
            r_ram_read    <= w_ram_read_nxt;
            r_ram_write   <= w_ram_write_nxt;
            r_ram_address <= w_ram_address_nxt;
            r_ram_data_in <= w_ram_data_in_nxt;
            r_rdata0      <= w_rdata0_nxt;
            r_rdata1      <= w_rdata1_nxt;
        end
    end

    assign done0       = r_done0;
    assign done1       = r_done1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign ram_read    = r_ram_read;
    assign ram_write   = r_ram_write;
    assign ram_address = r_ram_address;
    assign ram_data_in = r_ram_data_in;
    assign busy        = r_busy;
    assign grant       = r_grant;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 512x32 synchronous RAM between two requesters: port 0 = instruction fetch, port 1 = data load/store.
- Sits between the CPU control/datapath and the RAM. Owns the RAM read, write, address and data-in strobes.
- Serialises one access at a time with round-robin fairness and a req/done handshake per port.

Parameters:
- ADDR_W, 9, RAM address width (512 words).
- DATA_W, 32, RAM data width.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- clear_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held high until done0.
- we0  in  1  port 0 write enable (1 = write, 0 = read); stable while req0 is high.
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  DATA_W  port 0 write data.
- done0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  DATA_W  port 0 read data; valid while done0 is high.
- req1, we1, addr1, wdata1, done1, rdata1: same as port 0, for port 1.
- ram_read  out  1  RAM read strobe.
- ram_write  out  1  RAM write strobe.
- ram_address  out  ADDR_W  RAM address.
- ram_data_in  out  DATA_W  RAM write data.
- ram_data_out  in  DATA_W  RAM registered read data (1-cycle latency).
- busy  out  1  high in any state other than IDLE.
- grant  out  1  port currently owning the RAM; meaningful only while busy.

Behaviour:
- Reset (clear_n low, asynchronous):
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - done0, done1, ram_read, ram_write, busy = 0.
  - grant, ram_address, ram_data_in = 0; rdata0, rdata1 = 0.
- FSM has three states: IDLE, ACCESS, CAPTURE. All outputs are registered.
- IDLE:
  - A port is eligible if its req is high and its done is not high this cycle. The done mask stops a same-cycle re-grant while the requester drops req.
  - If no port is eligible, stay in IDLE.
  - If exactly one port is eligible, grant it.
  - If both are eligible, grant the port != last_grant.
  - On a grant: at the next edge go to ACCESS; load grant and last_grant; load ram_address = addr of the granted port.
  - Read grant: ram_read = 1. Write grant: ram_write = 1 and ram_data_in = wdata.
- ACCESS: strobes are held for exactly one cycle. The RAM samples them at the edge ending ACCESS. Next: CAPTURE, with ram_read, ram_write = 0.
- CAPTURE:
  - ram_data_out now holds memory[address]. On a write this is the old contents (read-before-write).
  - At the edge ending CAPTURE: return to IDLE and set done<grant> = 1.
  - For a read, also load rdata<grant> = ram_data_out. For a write, rdata<grant> is unchanged.
- Completion: done pulses for exactly one cycle, in the first IDLE cycle after CAPTURE; it is cleared on the following edge.
- Latency: req sampled high at edge E → strobes visible after E → done high after edge E+2.
  - Minimum back-to-back spacing is 3 cycles per access; the arbiter may re-grant in the same cycle done is high, to the other port only.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1.
- Requester changes addr/we/wdata mid-transaction: values were captured at grant, so the change is ignored.
- req dropped mid-transaction: the access completes and done still pulses (no abort).
- Reset mid-operation: returns to IDLE immediately and strobes drop asynchronously.
  - If clear_n falls before the edge ending ACCESS, the write does not occur.
  - No done pulse is issued for the interrupted access.
- Address width equals the RAM depth exactly; no out-of-range case exists.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding: IDLE = 2'd0, ACCESS = 2'd1, CAPTURE = 2'd2;
  - port ids: PORT_FETCH = 1'b0, PORT_DATA = 1'b1;
  - ADDR_W and DATA_W defaults.
- One sub-module: rr_pick2, the combinational 2-way round-robin chooser. Inputs: eligible[1:0], last_grant. Outputs: valid, pick.

Test Plan:
- Read only: preload memory[149] = 0x000000FF; req1 = 1, we1 = 0, addr1 = 149 → ram_read high for one cycle; done1 pulses 3 edges after req; rdata1 = 0x000000FF; done0 stays 0.
- Write then read: port 1 writes 0xDEADBEEF to addr 5, then reads addr 5 → rdata1 = 0xDEADBEEF. The write transaction leaves rdata1 unchanged.
- Contention: req0 and req1 raised together after reset and held → grant order 0,1,0,1. Each done is spaced 3 cycles apart; addr0 = 0 returns 0x01000095.
- Mask rule: port 0 re-raises req immediately after done0 while port 1 is idle → port 0 is not re-granted during the done0 cycle; it is granted on the next cycle.
- Reset mid-ACCESS: port 1 writes 0x12345678 to addr 7; pull clear_n low during ACCESS, before the edge → ram_write drops at once; no done1; memory[7] keeps its old value; busy = 0.
- Mid-transaction change: alter addr0 from 0 to 149 during ACCESS → the read still returns memory[0] = 0x01000095.
